// File: rtl/spi_flash_pkg.sv
// Shared definitions for the M25P16 identification/status responder and its SPI master.
package spi_flash_pkg;

  localparam logic [7:0] OPC_RDID_DEF        = 8'h9F;
  localparam logic [7:0] OPC_RDSR_DEF        = 8'h05;
  localparam logic [7:0] MANUFACTURER_ID_DEF = 8'h20;
  localparam logic [7:0] MEMORY_TYPE_DEF     = 8'h20;
  localparam logic [7:0] MEMORY_CAPACITY_DEF = 8'h15;

  localparam logic [4:0] RDID_RESP_BITS = 5'd24;
  localparam logic [4:0] CMD_LAST_BIT   = 5'd7;
  localparam logic [4:0] BIT_CNT_MAX    = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_RESP   = 2'd2,
    ST_IGNORE = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a history flop; emits one-clk rise/fall pulses.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_hist <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_hist;
  assign o_fall  = ~r_sync & r_hist;

endmodule

// File: rtl/spi_flash_id_responder.sv
// SPI mode-0 responder answering RDID and RDSR like an M25P16, oversampled by clk.
//
// state  | meaning
// IDLE   | deselected, waiting for a fresh chip_select falling edge
// CMD    | shifting in the 8-bit opcode on SCLK rises
// RESP   | driving the response on SCLK falls, MSB first
// IGNORE | unsupported opcode or RDID exhausted; wait for deselect
module spi_flash_id_responder
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] MANUFACTURER_ID = MANUFACTURER_ID_DEF,
  parameter logic [7:0] MEMORY_TYPE     = MEMORY_TYPE_DEF,
  parameter logic [7:0] MEMORY_CAPACITY = MEMORY_CAPACITY_DEF,
  parameter logic [7:0] OPC_RDID        = OPC_RDID_DEF,
  parameter logic [7:0] OPC_RDSR        = OPC_RDSR_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SPICLK,
  input  logic       SPIMOSI,
  input  logic       chip_select,
  input  logic [7:0] status_reg,
  output logic       SPIMISO,
  output logic       SPIMISO_oe,
  output logic [7:0] opcode,
  output logic       opcode_valid,
  output logic       busy
);

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_mosi_level, w_mosi_rise, w_mosi_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_unused;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .reset   (reset),
    .i_async (SPICLK),
    .o_level (w_sclk_level),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .reset   (reset),
    .i_async (SPIMOSI),
    .o_level (w_mosi_level),
    .o_rise  (w_mosi_rise),
    .o_fall  (w_mosi_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .reset   (reset),
    .i_async (chip_select),
    .o_level (w_cs_level),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  assign w_unused = ^{w_sclk_level, w_mosi_rise, w_mosi_fall};

  spi_state_e  r_state;
  spi_state_e  w_next_state;
  logic [4:0]  r_bit_cnt;
  logic [7:0]  r_cmd_sr;
  logic [23:0] r_resp_sr;
  logic        r_is_rdsr;
  logic        r_miso;
  logic [7:0]  r_opcode;
  logic        r_opcode_valid;
  logic [1:0]  r_settle;
  logic        r_armed;

  logic [7:0]  w_opc_next;
  logic        w_opc_known;
  logic        w_start;
  logic        w_cmd_done;
  logic        w_rdid_end;

  assign w_opc_next  = {r_cmd_sr[6:0], w_mosi_level};
  assign w_opc_known = (w_opc_next == OPC_RDID) || (w_opc_next == OPC_RDSR);
  assign w_start     = (r_state == ST_IDLE) && w_cs_fall && r_armed;
  assign w_cmd_done  = (r_state == ST_CMD) && w_sclk_rise && (r_bit_cnt == CMD_LAST_BIT);
  assign w_rdid_end  = (r_state == ST_RESP) && !r_is_rdsr && w_sclk_fall &&
                       (r_bit_cnt == RDID_RESP_BITS);

  // A chip_select that was already low when reset released must not start a frame;
  // arm only once the synchronizer has settled and seen the bus deselected.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle <= 2'd0;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      if ((r_settle == 2'd3) && w_cs_level) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_cs_rise) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_start)    w_next_state = ST_CMD;
        ST_CMD:    if (w_cmd_done) w_next_state = w_opc_known ? ST_RESP : ST_IGNORE;
        ST_RESP:   if (w_rdid_end) w_next_state = ST_IGNORE;
        ST_IGNORE: w_next_state = ST_IGNORE;
        default:   w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    SPIMISO_oe   = (r_state == ST_RESP);
    SPIMISO      = r_miso & (r_state == ST_RESP);
    busy         = (r_state != ST_IDLE);
    opcode       = r_opcode;
    opcode_valid = r_opcode_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt      <= 5'd0;
      r_cmd_sr       <= 8'h00;
      r_resp_sr      <= 24'h000000;
      r_is_rdsr      <= 1'b0;
      r_miso         <= 1'b0;
      r_opcode       <= 8'h00;
      r_opcode_valid <= 1'b0;
    end else begin
      r_opcode_valid <= 1'b0;
      if (w_cs_rise) begin
        r_miso <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_miso <= 1'b0;
            if (w_start) begin
              r_bit_cnt <= 5'd0;
              r_cmd_sr  <= 8'h00;
            end
          end
          ST_CMD: begin
            r_miso <= 1'b0;
            if (w_sclk_rise) begin
              r_cmd_sr <= w_opc_next;
              if (r_bit_cnt == CMD_LAST_BIT) begin
                r_opcode       <= w_opc_next;
                r_opcode_valid <= 1'b1;
                r_is_rdsr      <= (w_opc_next == OPC_RDSR);
                r_resp_sr      <= (w_opc_next == OPC_RDSR) ? {status_reg, 16'h0000} :
                                  {MANUFACTURER_ID, MEMORY_TYPE, MEMORY_CAPACITY};
                r_bit_cnt      <= 5'd0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          ST_RESP: begin
            if (w_sclk_fall) begin
              if (r_is_rdsr) begin
                r_miso <= r_resp_sr[23];
                // Last bit of a status byte: refresh so the next byte shows live status.
                if (r_bit_cnt[2:0] == 3'd7) begin
                  r_resp_sr <= {status_reg, 16'h0000};
                  r_bit_cnt <= 5'd0;
                end else begin
                  r_resp_sr <= {r_resp_sr[22:0], 1'b0};
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                end
              end else if (r_bit_cnt == RDID_RESP_BITS) begin
                r_miso <= 1'b0;
              end else begin
                r_miso    <= r_resp_sr[23];
                r_resp_sr <= {r_resp_sr[22:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          ST_IGNORE: begin
            r_miso <= 1'b0;
            if (w_sclk_rise && (r_bit_cnt != BIT_CNT_MAX)) r_bit_cnt <= r_bit_cnt + 5'd1;
          end
          default: r_miso <= 1'b0;
        endcase
      end
    end
  end

endmodule
